// File: rtl/bin2onehot_decoder_reg_if.sv
// Handshake bundle for bin2onehot_decoder_reg: index/mode input side, code/error output side.
interface bin2onehot_decoder_reg_if #(
  parameter int BIN_W     = 3,
  parameter int OUT_W     = 8,
  parameter int ERR_CNT_W = 8
);
  logic [BIN_W-1:0]     Bin;
  logic [1:0]           Mode;
  logic                 in_valid;
  logic                 in_ready;
  logic                 Rot;
  logic [OUT_W-1:0]     OneHotCode;
  logic                 out_valid;
  logic                 out_ready;
  logic                 err;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (
    output Bin, Mode, in_valid, Rot, out_ready,
    input  in_ready, OneHotCode, out_valid, err, err_cnt
  );

  modport slave (
    input  Bin, Mode, in_valid, Rot, out_ready,
    output in_ready, OneHotCode, out_valid, err, err_cnt
  );
endinterface

// File: rtl/bin2onehot_decoder_reg.sv
// Registered binary-to-code decoder (one-hot / thermometer / one-cold) with a one-entry
// valid/ready stage, in-place index rotation and a saturating out-of-range counter.
module bin2onehot_decoder_reg #(
  parameter int BIN_W     = 3,
  parameter int OUT_W     = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  bin2onehot_decoder_reg_if.slave    bus
);

  typedef enum logic [1:0] {
    ModeOneHot  = 2'b00,
    ModeTherm   = 2'b01,
    ModeOneCold = 2'b10,
    ModeAlias   = 2'b11
  } mode_t;

  // One extra bit so OUT_W == 2**BIN_W is representable as the range limit.
  localparam logic [BIN_W:0]   OutWLim = (BIN_W+1)'(OUT_W);
  localparam logic [BIN_W-1:0] LastIdx = BIN_W'(OUT_W-1);

  logic [BIN_W-1:0]     idx;
  mode_t                mode;
  logic [OUT_W-1:0]     code;
  logic                 outValid;
  logic                 errQ;
  logic [ERR_CNT_W-1:0] errCnt;

  logic                 inReady;
  logic                 accept;
  logic                 consume;
  logic                 rotate;
  logic                 binOor;
  logic [BIN_W-1:0]     rotIdx;

  function automatic logic outOfRange(input logic [BIN_W-1:0] k);
    return {1'b0, k} >= OutWLim;
  endfunction

  function automatic logic [OUT_W-1:0] encode(input logic [BIN_W-1:0] k, input mode_t m);
    logic [OUT_W-1:0] c;
    logic [31:0]      kk;
    c  = '0;
    kk = 32'(k);
    if (!outOfRange(k)) begin
      for (int unsigned i = 0; i < OUT_W; i++) begin
        case (m)
          ModeTherm:   c[i] = (i <= kk);
          ModeOneCold: c[i] = (i != kk);
          default:     c[i] = (i == kk);
        endcase
      end
    end
    return c;
  endfunction

  always_comb begin
    inReady = !outValid || bus.out_ready;
    accept  = bus.in_valid && inReady;
    consume = outValid && bus.out_ready;
    rotate  = bus.Rot && outValid && !errQ && !bus.out_ready;
    binOor  = outOfRange(bus.Bin);
    rotIdx  = (idx == LastIdx) ? '0 : idx + BIN_W'(1);
  end

  // Priority: reset > accept > consume > rotate.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx      <= '0;
      mode     <= ModeOneHot;
      code     <= '0;
      outValid <= 1'b0;
      errQ     <= 1'b0;
      errCnt   <= '0;
    end else if (accept) begin
      idx      <= bus.Bin;
      mode     <= mode_t'(bus.Mode);
      code     <= encode(bus.Bin, mode_t'(bus.Mode));
      outValid <= 1'b1;
      errQ     <= binOor;
      if (binOor && (errCnt != '1)) begin
        errCnt <= errCnt + ERR_CNT_W'(1);
      end
    end else if (consume) begin
      outValid <= 1'b0;
    end else if (rotate) begin
      idx  <= rotIdx;
      code <= encode(rotIdx, mode);
    end
  end

  assign bus.in_ready   = inReady;
  assign bus.OneHotCode = code;
  assign bus.out_valid  = outValid;
  assign bus.err        = errQ;
  assign bus.err_cnt    = errCnt;

endmodule

// File: tb/tb_bin2onehot_decoder_reg.sv
// Bench for bin2onehot_decoder_reg: directed scenarios on an 8-wide and a 6-wide instance,
// then randomized traffic against a transaction-level reference model.
module tb_bin2onehot_decoder_reg;

  logic clk = 1'b0;
  logic reset;
  int   nCompared = 0;
  int   nMismatched = 0;

  always #5 clk = ~clk;

  bin2onehot_decoder_reg_if #(.BIN_W(3), .OUT_W(8), .ERR_CNT_W(8)) bus8 ();
  bin2onehot_decoder_reg_if #(.BIN_W(3), .OUT_W(6), .ERR_CNT_W(2)) bus6 ();

  bin2onehot_decoder_reg #(.BIN_W(3), .OUT_W(8), .ERR_CNT_W(8)) dut8 (
    .clk(clk), .reset(reset), .bus(bus8)
  );
  bin2onehot_decoder_reg #(.BIN_W(3), .OUT_W(6), .ERR_CNT_W(2)) dut6 (
    .clk(clk), .reset(reset), .bus(bus6)
  );

  // Reference code from arithmetic on the index; zero for out-of-range indices.
  function automatic logic [7:0] expCode(input int idx, input int mode, input int outW);
    longint one  = 1;
    longint mask = (one << outW) - 1;
    longint v;
    if (idx >= outW) return 8'h00;
    case (mode)
      1:       v = (one << (idx + 1)) - 1;
      2:       v = mask & ~(one << idx);
      default: v = one << idx;
    endcase
    return 8'(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleAll();
    bus8.in_valid = 0; bus8.Rot = 0; bus8.out_ready = 0; bus8.Bin = '0; bus8.Mode = 2'b00;
    bus6.in_valid = 0; bus6.Rot = 0; bus6.out_ready = 0; bus6.Bin = '0; bus6.Mode = 2'b00;
  endtask

  task automatic test_reset();
    idleAll();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    nCompared++; if (bus8.out_valid !== 1'b0) begin nMismatched++; $display("FAIL reset_out_valid got=%b exp=0", bus8.out_valid); end
    nCompared++; if (bus8.OneHotCode !== 8'h00) begin nMismatched++; $display("FAIL reset_code got=%b exp=00000000", bus8.OneHotCode); end
    nCompared++; if (bus8.err !== 1'b0) begin nMismatched++; $display("FAIL reset_err got=%b exp=0", bus8.err); end
    nCompared++; if (bus8.err_cnt !== 8'd0) begin nMismatched++; $display("FAIL reset_err_cnt got=%0d exp=0", bus8.err_cnt); end
    nCompared++; if (bus8.in_ready !== 1'b1) begin nMismatched++; $display("FAIL reset_in_ready got=%b exp=1", bus8.in_ready); end
    nCompared++; if (bus6.err_cnt !== 2'd0) begin nMismatched++; $display("FAIL reset_err_cnt6 got=%0d exp=0", bus6.err_cnt); end
  endtask

  task automatic test_onehot_sweep();
    logic [7:0] exp;
    bus8.out_ready = 1; bus8.in_valid = 1; bus8.Mode = 2'b00;
    for (int b = 0; b < 8; b++) begin
      bus8.Bin = 3'(b);
      #1;
      nCompared++; if (bus8.in_ready !== 1'b1) begin nMismatched++; $display("FAIL sweep_in_ready bin=%0d got=%b exp=1", b, bus8.in_ready); end
      tick();
      exp = 8'(1 << b);
      nCompared++; if (bus8.OneHotCode !== exp) begin nMismatched++; $display("FAIL sweep_code bin=%0d got=%b exp=%b", b, bus8.OneHotCode, exp); end
      nCompared++; if (bus8.out_valid !== 1'b1 || bus8.err !== 1'b0) begin nMismatched++; $display("FAIL sweep_valid_err bin=%0d got=%b%b exp=10", b, bus8.out_valid, bus8.err); end
    end
    bus8.in_valid = 0;
    tick();
    nCompared++; if (bus8.out_valid !== 1'b0) begin nMismatched++; $display("FAIL sweep_drain got=%b exp=0", bus8.out_valid); end
  endtask

  task automatic test_modes();
    logic [7:0] expTab [3] = '{8'b00111111, 8'b11011111, 8'b00100000};
    bus8.out_ready = 1; bus8.in_valid = 1; bus8.Bin = 3'd5;
    for (int m = 1; m < 4; m++) begin
      bus8.Mode = 2'(m);
      tick();
      nCompared++; if (bus8.OneHotCode !== expTab[m-1]) begin nMismatched++; $display("FAIL mode_code mode=%0d got=%b exp=%b", m, bus8.OneHotCode, expTab[m-1]); end
    end
    bus8.in_valid = 0;
    tick();
  endtask

  task automatic test_rotation();
    logic [7:0] expTab [2][4] = '{'{8'b01000000, 8'b10000000, 8'b00000001, 8'b00000010},
                                   '{8'b01111111, 8'b11111111, 8'b00000001, 8'b00000011}};
    for (int m = 0; m < 2; m++) begin
      bus8.in_valid = 1; bus8.Bin = 3'd6; bus8.Mode = 2'(m); bus8.out_ready = 0; bus8.Rot = 0;
      tick();
      bus8.in_valid = 0; bus8.Rot = 1;
      for (int s = 0; s < 4; s++) begin
        nCompared++; if (bus8.OneHotCode !== expTab[m][s] || bus8.out_valid !== 1'b1) begin
          nMismatched++; $display("FAIL rot_code mode=%0d step=%0d got=%b v=%b exp=%b v=1", m, s, bus8.OneHotCode, bus8.out_valid, expTab[m][s]);
        end
        if (s < 3) tick();
      end
      bus8.Rot = 0; bus8.out_ready = 1;
      tick();
    end
  endtask

  task automatic test_backpressure();
    bus8.in_valid = 1; bus8.Bin = 3'd2; bus8.Mode = 2'b00; bus8.out_ready = 0;
    tick();
    for (int b = 3; b < 5; b++) begin
      bus8.Bin = 3'(b);
      #1;
      nCompared++; if (bus8.in_ready !== 1'b0) begin nMismatched++; $display("FAIL bp_in_ready got=%b exp=0", bus8.in_ready); end
      tick();
      nCompared++; if (bus8.OneHotCode !== 8'b00000100) begin nMismatched++; $display("FAIL bp_hold got=%b exp=00000100", bus8.OneHotCode); end
    end
    bus8.Bin = 3'd7; bus8.out_ready = 1;
    #1;
    nCompared++; if (bus8.in_ready !== 1'b1) begin nMismatched++; $display("FAIL bp_release_ready got=%b exp=1", bus8.in_ready); end
    tick();
    nCompared++; if (bus8.OneHotCode !== 8'b10000000 || bus8.out_valid !== 1'b1) begin
      nMismatched++; $display("FAIL bp_new_code got=%b v=%b exp=10000000 v=1", bus8.OneHotCode, bus8.out_valid);
    end
    bus8.in_valid = 0;
    tick();
  endtask

  task automatic test_out_of_range();
    int binSeq [5] = '{6, 7, 6, 7, 6};
    int cntSeq [5] = '{1, 2, 3, 3, 3};
    bus6.out_ready = 1; bus6.in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      bus6.Bin = 3'(binSeq[i]); bus6.Mode = 2'(i % 4);
      tick();
      nCompared++; if (bus6.OneHotCode !== 6'b000000 || bus6.err !== 1'b1) begin
        nMismatched++; $display("FAIL oor_code bin=%0d got=%b err=%b exp=000000 err=1", binSeq[i], bus6.OneHotCode, bus6.err);
      end
      nCompared++; if (bus6.err_cnt !== 2'(cntSeq[i])) begin nMismatched++; $display("FAIL oor_cnt step=%0d got=%0d exp=%0d", i, bus6.err_cnt, cntSeq[i]); end
    end
    bus6.in_valid = 0; bus6.out_ready = 0; bus6.Rot = 1;
    tick(); tick();
    nCompared++; if (bus6.OneHotCode !== 6'b000000 || bus6.err !== 1'b1 || bus6.out_valid !== 1'b1) begin
      nMismatched++; $display("FAIL oor_rot_ignored got=%b err=%b v=%b exp=000000 err=1 v=1", bus6.OneHotCode, bus6.err, bus6.out_valid);
    end
    bus6.Rot = 0; bus6.in_valid = 1; bus6.Bin = 3'd5; bus6.Mode = 2'b00; bus6.out_ready = 1;
    tick();
    nCompared++; if (bus6.OneHotCode !== 6'b100000 || bus6.err !== 1'b0 || bus6.err_cnt !== 2'd3) begin
      nMismatched++; $display("FAIL oor_inrange got=%b err=%b cnt=%0d exp=100000 err=0 cnt=3", bus6.OneHotCode, bus6.err, bus6.err_cnt);
    end
    bus6.in_valid = 0; bus6.out_ready = 0; bus6.Rot = 1;
    tick();
    nCompared++; if (bus6.OneHotCode !== 6'b000001) begin nMismatched++; $display("FAIL oor_wrap6 got=%b exp=000001", bus6.OneHotCode); end
    bus6.Rot = 0;
  endtask

  task automatic test_reset_mid();
    bus8.in_valid = 1; bus8.Bin = 3'd3; bus8.Mode = 2'b01; bus8.out_ready = 0;
    tick();
    bus8.in_valid = 0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    nCompared++; if (bus8.out_valid !== 1'b0 || bus8.OneHotCode !== 8'h00 || bus8.err !== 1'b0) begin
      nMismatched++; $display("FAIL rstmid_state got v=%b code=%b err=%b exp v=0 code=00000000 err=0", bus8.out_valid, bus8.OneHotCode, bus8.err);
    end
    nCompared++; if (bus8.in_ready !== 1'b1) begin nMismatched++; $display("FAIL rstmid_in_ready got=%b exp=1", bus8.in_ready); end
    nCompared++; if (bus6.err_cnt !== 2'd0 || bus6.out_valid !== 1'b0) begin
      nMismatched++; $display("FAIL rstmid_dut6 got cnt=%0d v=%b exp cnt=0 v=0", bus6.err_cnt, bus6.out_valid);
    end
  endtask

  task automatic test_random();
    int outW [2]   = '{8, 6};
    int cntMax [2] = '{255, 3};
    bit mValid [2] = '{0, 0};
    int mIdx [2]   = '{0, 0};
    int mMode [2]  = '{0, 0};
    int mCnt [2]   = '{0, 0};
    bit iv [2], rot [2], ordy [2];
    int b [2], m [2];
    logic       obsValid [2], obsErr [2], obsReady [2];
    logic [7:0] obsCode [2], exp;
    int         obsCnt [2];
    idleAll();
    for (int cyc = 0; cyc < 500; cyc++) begin
      for (int d = 0; d < 2; d++) begin
        iv[d] = ($urandom_range(0, 9) < 6); rot[d] = ($urandom_range(0, 9) < 5);
        ordy[d] = ($urandom_range(0, 9) < 4); b[d] = $urandom_range(0, 7); m[d] = $urandom_range(0, 3);
      end
      bus8.in_valid = iv[0]; bus8.Rot = rot[0]; bus8.out_ready = ordy[0]; bus8.Bin = 3'(b[0]); bus8.Mode = 2'(m[0]);
      bus6.in_valid = iv[1]; bus6.Rot = rot[1]; bus6.out_ready = ordy[1]; bus6.Bin = 3'(b[1]); bus6.Mode = 2'(m[1]);
      #1;
      obsReady[0] = bus8.in_ready; obsReady[1] = bus6.in_ready;
      for (int d = 0; d < 2; d++) begin
        nCompared++; if (obsReady[d] !== (!mValid[d] || ordy[d])) begin
          nMismatched++; $display("FAIL rnd_in_ready dut=%0d cyc=%0d got=%b exp=%b", outW[d], cyc, obsReady[d], (!mValid[d] || ordy[d]));
        end
        if (iv[d] && (!mValid[d] || ordy[d])) begin
          mValid[d] = 1; mIdx[d] = b[d]; mMode[d] = m[d];
          if (b[d] >= outW[d] && mCnt[d] < cntMax[d]) mCnt[d]++;
        end else if (mValid[d] && ordy[d]) begin
          mValid[d] = 0;
        end else if (mValid[d] && rot[d] && mIdx[d] < outW[d]) begin
          mIdx[d] = (mIdx[d] + 1) % outW[d];
        end
      end
      tick();
      obsValid[0] = bus8.out_valid; obsErr[0] = bus8.err; obsCode[0] = bus8.OneHotCode;        obsCnt[0] = int'(bus8.err_cnt);
      obsValid[1] = bus6.out_valid; obsErr[1] = bus6.err; obsCode[1] = {2'b00, bus6.OneHotCode}; obsCnt[1] = int'(bus6.err_cnt);
      for (int d = 0; d < 2; d++) begin
        nCompared++; if (obsValid[d] !== mValid[d]) begin nMismatched++; $display("FAIL rnd_valid dut=%0d cyc=%0d got=%b exp=%b", outW[d], cyc, obsValid[d], mValid[d]); end
        nCompared++; if (obsCnt[d] != mCnt[d]) begin nMismatched++; $display("FAIL rnd_cnt dut=%0d cyc=%0d got=%0d exp=%0d", outW[d], cyc, obsCnt[d], mCnt[d]); end
        if (mValid[d]) begin
          exp = expCode(mIdx[d], mMode[d], outW[d]);
          nCompared++; if (obsCode[d] !== exp || obsErr[d] !== (mIdx[d] >= outW[d])) begin
            nMismatched++; $display("FAIL rnd_code dut=%0d cyc=%0d got=%b err=%b exp=%b err=%b", outW[d], cyc, obsCode[d], obsErr[d], exp, (mIdx[d] >= outW[d]));
          end
        end
      end
    end
    idleAll();
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_onehot_sweep();
    test_modes();
    test_rotation();
    test_backpressure();
    test_out_of_range();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/bin2onehot_decoder_reg.md
Name: bin2onehot_decoder_reg

Overview:
- Registered, parametrised successor to the 3-to-8 binary-to-one-hot decoder.
- Converts a BIN_W-bit index into an OUT_W-bit code with valid/ready handshakes on both sides.
- Code modes: one-hot, thermometer, one-cold.
- Adds in-place index rotation (walk) and out-of-range detection with a saturating error counter.
- Sits between control logic that produces indices and consumers needing select or enable vectors, e.g. mux selects or channel enables.

Parameters:
- BIN_W, 3, width of the binary index input.
- OUT_W, 8, output code width; legal range 2 to 2**BIN_W. Non-power-of-2 values are legal.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- Bin  in  BIN_W  binary index.
- Mode  in  2  code mode, sampled with Bin: 00 one-hot, 01 thermometer, 10 one-cold, 11 treated as 00.
- in_valid  in  1  Bin/Mode valid.
- in_ready  out  1  block can accept an input this cycle.
- Rot  in  1  request to advance the held index by one.
- OneHotCode  out  OUT_W  registered code.
- out_valid  out  1  OneHotCode/err valid.
- out_ready  in  1  consumer accepts the output.
- err  out  1  held index was out of range (Bin >= OUT_W).
- err_cnt  out  ERR_CNT_W  count of accepted out-of-range inputs, saturating.

Behaviour:
- Clocking and reset: single clock. Reset is synchronous and active-high. Every output is registered except in_ready.
- Reset values: OneHotCode = 0, out_valid = 0, err = 0, err_cnt = 0. Internal idx = 0 and mode = 00. in_ready = 1 once reset is low.
- Reset mid-transfer discards any held output; no partial state survives.
- Input acceptance (accept) = in_valid & in_ready, where in_ready = !out_valid | out_ready. This gives a one-entry pipeline with full throughput.
- On accept, the next cycle has out_valid = 1 with idx = Bin and mode = Mode registered. Latency is 1 cycle.
- Code generation from (idx, mode), with k = idx:
  - One-hot: bit k = 1, all others 0.
  - Thermometer: bits 0..k = 1, all others 0 (k = 0 gives 0...01; k = OUT_W-1 gives all ones).
  - One-cold: bitwise inverse of one-hot.
- Out of range (Bin >= OUT_W, only possible when OUT_W < 2**BIN_W):
  - OneHotCode = 0 in every mode and err = 1.
  - err_cnt increments by 1, saturating at all ones.
  - The entry is still delivered through the handshake.
- Output is consumed when out_valid & out_ready. If no accept occurs in the same cycle, out_valid falls next cycle and OneHotCode/err keep their last values (don't-care).
- Rotation applies when Rot = 1, out_valid = 1, err = 0, out_ready = 0 and there is no accept.
  - idx <= (idx == OUT_W-1) ? 0 : idx+1, and the code is recomputed in the stored mode.
  - One-hot and one-cold wrap MSB back to bit 0. Thermometer wraps from all ones back to 0...01.
  - out_valid stays 1. Rotation changes the held value without a handshake, so the consumer samples whatever is present at its accept.
- Priority in the same cycle: reset > accept > consume > Rot. Rot is ignored when out_valid = 0, when err = 1, or on any cycle with out_ready = 1.
- Backpressure: while out_valid & !out_ready, OneHotCode is stable except under Rot, in_ready = 0, and Bin is not sampled.
- Width rules: the idx compare uses BIN_W bits unsigned. The counter never wraps.

Test Plan:
- Exhaustive one-hot sweep: defaults, Mode = 00, out_ready = 1, Bin = 0..7 back-to-back -> OneHotCode = 00000001, 00000010, ..., 10000000 one cycle after each accept. in_ready stays 1 and err = 0 throughout.
- Modes: Bin = 5 with Mode = 01 -> 00111111. Mode = 10 -> 11011111. Mode = 11 -> 00100000.
- Rotation and wrap: Bin = 6, Mode = 00, out_ready = 0, Rot = 1 for 3 cycles -> 01000000, 10000000, 00000001, 00000010. Repeat with Mode = 01: 01111111, 11111111, 00000001, 00000011.
- Backpressure: out_ready = 0 with in_valid = 1 and Bin changing -> in_ready = 0 and OneHotCode holds. When out_ready = 1, the held entry transfers and the new Bin is accepted in the same cycle, with its code visible next cycle.
- Out of range (OUT_W = 6, BIN_W = 3, ERR_CNT_W = 2): Bin = 6, 7, 6, 7, 6 accepted -> OneHotCode = 000000 and err = 1 each time. err_cnt steps 1, 2, 3, 3, 3. Rot while err = 1 causes no change.
- Reset mid-operation: assert reset for 1 cycle while out_valid = 1 and out_ready = 0 -> next cycle out_valid = 0, OneHotCode = 0, err = 0, err_cnt = 0, in_ready = 1.
